// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encodings, opcode/ext fields,
// condition codes, writeback selects and the control-word payload.
package instr_sequencer_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM_RD = 3'd4;
    localparam logic [2:0] S_MEM_WR = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;

    localparam logic [3:0] OP_REG   = 4'h0;
    localparam logic [3:0] OP_EXT   = 4'h4;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_RSV_E = 4'hE;
    localparam logic [3:0] OP_RSV_F = 4'hF;

    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_CMP   = 4'hB;
    localparam logic [3:0] EXT_JCOND = 4'hC;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_HI = 4'h4;
    localparam logic [3:0] COND_LS = 4'h5;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_FS = 4'h8;
    localparam logic [3:0] COND_FC = 4'h9;
    localparam logic [3:0] COND_LO = 4'hA;
    localparam logic [3:0] COND_HS = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GE = 4'hD;
    localparam logic [3:0] COND_UC = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    typedef struct packed {
        logic       ir_load;
        logic       pc_en;
        logic       branch;
        logic       jump;
        logic [7:0] b_offset;
        logic       addr_sel;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       flags_we;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Register-form and immediate ALU ops: everything except the ext group, Bcond and reserved.
    function automatic logic is_alu_op(input logic [3:0] op);
        return !(op inside {OP_EXT, OP_BCOND, OP_RSV_E, OP_RSV_F});
    endfunction

    // Compares only update the PSR.
    function automatic logic alu_writes_reg(input logic [3:0] op, input logic [3:0] ext);
        return !((op == OP_REG && ext == EXT_CMP) || op == OP_CMPI);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> datapath/memory control bundle.
interface instr_sequencer_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] instr;
    logic [4:0]        flags;
    logic              mem_rdy;
    logic              ir_load;
    logic              pc_en;
    logic              branch;
    logic              jump;
    logic [7:0]        b_offset;
    logic              addr_sel;
    logic              mem_we;
    logic              reg_we;
    logic [1:0]        wb_sel;
    logic              flags_we;
    logic              mem_err;

    modport master (
        input  instr, flags, mem_rdy,
        output ir_load, pc_en, branch, jump, b_offset, addr_sel,
               mem_we, reg_we, wb_sel, flags_we, mem_err
    );

    modport slave (
        output instr, flags, mem_rdy,
        input  ir_load, pc_en, branch, jump, b_offset, addr_sel,
               mem_we, reg_we, wb_sel, flags_we, mem_err
    );
endinterface

// File: rtl/instr_sequencer_cond_check.sv
// Branch/jump condition evaluator over PSR flags {C,L,F,Z,N}.
module cond_check (
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       take
);
    logic flag_c, flag_l, flag_f, flag_z, flag_n;
    logic base;

    assign {flag_c, flag_l, flag_f, flag_z, flag_n} = flags;

    // Codes come in complementary pairs; cond[0] inverts the even member.
    always_comb begin
        base = 1'b0;
        case (cond[3:1])
            3'd0:    base = flag_z;
            3'd1:    base = flag_c;
            3'd2:    base = flag_l;
            3'd3:    base = flag_n;
            3'd4:    base = flag_f;
            3'd5:    base = !flag_l && !flag_z;
            3'd6:    base = !flag_n && !flag_z;
            default: base = 1'b1;
        endcase
        take = base ^ cond[0];
    end
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the CR16-subset core.
// Optional memory wait states and timeout under `SEQ_MEM_WAIT_EN.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 16
`ifdef SEQ_MEM_WAIT_EN
    , parameter int unsigned WAIT_MAX = 15
`endif
) (
    input logic              clk,
    input logic              reset,
    instr_sequencer_if.master bus
);
    logic [DATA_W-1:0] ir;
    logic [3:0]        op;
    logic [3:0]        ext;
    logic              take;
    logic [STATE_W-1:0] state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              hold;
    logic              tmo;

    assign ir  = bus.instr;
    assign op  = ir[15:12];
    assign ext = ir[7:4];

    cond_check u_cond_check (
        .cond  (ir[11:8]),
        .flags (bus.flags),
        .take  (take)
    );

    // Next state, then the control word of that state so outputs register alongside it.
    always_comb begin
        state_d = state_q;
        ctrl_d  = CTRL_IDLE;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (op == OP_EXT && ext == EXT_LOAD)      state_d = S_MEM_RD;
                else if (op == OP_EXT && ext == EXT_STOR) state_d = S_MEM_WR;
                else                                      state_d = S_FETCH;
            end
            S_MEM_RD: state_d = S_WB;
            S_MEM_WR: state_d = S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_INIT;
        endcase
        if (hold) state_d = state_q;
        if (tmo)  state_d = S_FETCH;

        case (state_d)
            S_FETCH: ctrl_d.ir_load = 1'b1;
            S_EXEC: begin
                if (op == OP_EXT) begin
                    case (ext)
                        EXT_LOAD, EXT_STOR: ctrl_d.addr_sel = 1'b1;
                        EXT_JAL: begin
                            ctrl_d.reg_we = 1'b1;
                            ctrl_d.wb_sel = WB_LINK;
                            ctrl_d.pc_en  = 1'b1;
                            ctrl_d.jump   = 1'b1;
                        end
                        EXT_JCOND: begin
                            ctrl_d.pc_en = 1'b1;
                            ctrl_d.jump  = take;
                        end
                        default: ctrl_d.pc_en = 1'b1;
                    endcase
                end else if (op == OP_BCOND) begin
                    ctrl_d.pc_en    = 1'b1;
                    ctrl_d.branch   = take;
                    ctrl_d.b_offset = take ? ir[7:0] : 8'h00;
                end else if (is_alu_op(op)) begin
                    ctrl_d.reg_we   = alu_writes_reg(op, ext);
                    ctrl_d.flags_we = 1'b1;
                    ctrl_d.wb_sel   = WB_ALU;
                    ctrl_d.pc_en    = 1'b1;
                end else begin
                    ctrl_d.pc_en = 1'b1;
                end
            end
            S_MEM_RD: ctrl_d.addr_sel = 1'b1;
            S_MEM_WR: begin
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.mem_we   = 1'b1;
                ctrl_d.pc_en    = 1'b1;
            end
            S_WB: begin
                ctrl_d.reg_we = 1'b1;
                ctrl_d.wb_sel = WB_MEM;
                ctrl_d.pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            ctrl_q  <= CTRL_IDLE;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.branch   = ctrl_q.branch;
    assign bus.jump     = ctrl_q.jump;
    assign bus.b_offset = ctrl_q.b_offset;
    assign bus.addr_sel = ctrl_q.addr_sel;
    assign bus.mem_we   = ctrl_q.mem_we;
    assign bus.reg_we   = ctrl_q.reg_we;
    assign bus.wb_sel   = ctrl_q.wb_sel;
    assign bus.flags_we = ctrl_q.flags_we;

`ifdef SEQ_MEM_WAIT_EN
    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 2);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             mem_err_q;
    logic             wait_st;

    assign wait_st = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign tmo     = wait_st && !bus.mem_rdy && (wait_cnt_q >= CNT_W'(WAIT_MAX));
    assign hold    = wait_st && !bus.mem_rdy && !tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= hold ? wait_cnt_q + CNT_W'(1) : '0;
            if (tmo) mem_err_q <= 1'b1;
        end
    end

    // Exit strobes of a memory state fire only in the ready cycle; a timeout skips the instruction.
    assign bus.ir_load = ctrl_q.ir_load && (!wait_st || bus.mem_rdy);
    assign bus.pc_en   = (ctrl_q.pc_en && (!wait_st || bus.mem_rdy)) || tmo;
    assign bus.mem_err = mem_err_q;
`else
    logic unused_mem_rdy;

    assign hold           = 1'b0;
    assign tmo            = 1'b0;
    assign unused_mem_rdy = bus.mem_rdy;
    assign bus.ir_load    = ctrl_q.ir_load;
    assign bus.pc_en      = ctrl_q.pc_en;
    assign bus.mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-instruction expected cycle sequences from an ISA-level model.
module tb_instr_sequencer;

    typedef struct packed {
        logic       ir_load;
        logic       pc_en;
        logic       branch;
        logic       jump;
        logic [7:0] b_offset;
        logic       addr_sel;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       flags_we;
        logic       mem_err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic model_err;

    exp_t  exp_q[$];
    string name_q[$];

    instr_sequencer_if sif ();

    instr_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cond_true(input logic [3:0] c, input logic [4:0] f);
        logic fc, fl, ff, fz, fn;
        {fc, fl, ff, fz, fn} = f;
        case (c)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fl;
            4'h5: return !fl;
            4'h6: return fn;
            4'h7: return !fn;
            4'h8: return ff;
            4'h9: return !ff;
            4'hA: return !fl && !fz;
            4'hB: return fl || fz;
            4'hC: return !fn && !fz;
            4'hD: return fn || fz;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e = '0;
        e.mem_err = model_err;
        return e;
    endfunction

    function automatic exp_t model_exec(input logic [15:0] w, input logic [4:0] f);
        exp_t e;
        logic [3:0] op, ext;
        logic t;
        e   = blank();
        op  = w[15:12];
        ext = w[7:4];
        t   = cond_true(w[11:8], f);
        if (op == 4'h4 && (ext == 4'h0 || ext == 4'h4)) begin
            e.addr_sel = 1'b1;
        end else if (op == 4'h4 && ext == 4'h8) begin
            e.reg_we = 1'b1; e.wb_sel = 2'd2; e.pc_en = 1'b1; e.jump = 1'b1;
        end else if (op == 4'h4 && ext == 4'hC) begin
            e.pc_en = 1'b1; e.jump = t;
        end else if (op == 4'hC) begin
            e.pc_en = 1'b1; e.branch = t; e.b_offset = t ? w[7:0] : 8'h00;
        end else if (op == 4'h4 || op == 4'hE || op == 4'hF) begin
            e.pc_en = 1'b1;
        end else begin
            e.pc_en = 1'b1; e.flags_we = 1'b1;
            e.reg_we = !(op == 4'hB || (op == 4'h0 && ext == 4'hB));
        end
        return e;
    endfunction

    function automatic int model_len(input logic [15:0] w);
        if (w[15:12] == 4'h4 && w[7:4] == 4'h0) return 5;
        if (w[15:12] == 4'h4 && w[7:4] == 4'h4) return 4;
        return 3;
    endfunction

    task automatic expect_cycle(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic push_instr(input string nm, input logic [15:0] w, input logic [4:0] f);
        exp_t e;
        e = blank(); e.ir_load = 1'b1;
        expect_cycle({nm, "_fetch"}, e);
        expect_cycle({nm, "_decode"}, blank());
        expect_cycle({nm, "_exec"}, model_exec(w, f));
        if (model_len(w) == 5) begin
            e = blank(); e.addr_sel = 1'b1;
            expect_cycle({nm, "_memrd"}, e);
            e = blank(); e.reg_we = 1'b1; e.wb_sel = 2'd1; e.pc_en = 1'b1;
            expect_cycle({nm, "_wb"}, e);
        end else if (model_len(w) == 4) begin
            e = blank(); e.addr_sel = 1'b1; e.mem_we = 1'b1; e.pc_en = 1'b1;
            expect_cycle({nm, "_memwr"}, e);
        end
    endtask

    // Called just after the edge that enters FETCH; returns just after the next FETCH edge.
    task automatic run(input string nm, input logic [15:0] w, input logic [4:0] f);
        push_instr(nm, w, f);
        sif.instr = w;
        sif.flags = f;
        repeat (model_len(w)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pin(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {sif.ir_load, sif.pc_en, sif.branch, sif.jump, sif.b_offset, sif.addr_sel,
                  sif.mem_we, sif.reg_we, sif.wb_sel, sif.flags_we, sif.mem_err};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s @%0t: got il=%b pc=%b br=%b jp=%b off=%h as=%b mw=%b rw=%b wb=%0d fw=%b err=%b, want il=%b pc=%b br=%b jp=%b off=%h as=%b mw=%b rw=%b wb=%0d fw=%b err=%b",
                         nm, $time, a.ir_load, a.pc_en, a.branch, a.jump, a.b_offset, a.addr_sel,
                         a.mem_we, a.reg_we, a.wb_sel, a.flags_we, a.mem_err,
                         e.ir_load, e.pc_en, e.branch, e.jump, e.b_offset, e.addr_sel,
                         e.mem_we, e.reg_we, e.wb_sel, e.flags_we, e.mem_err);
            end
        end
    end

    initial begin
        exp_t e;
        checks      = 0;
        failures    = 0;
        model_err   = 1'b0;
        reset       = 1'b1;
        sif.instr   = 16'h0000;
        sif.flags   = 5'b00000;
        sif.mem_rdy = 1'b1;

        // Hand-computed pins on the model itself.
        e = model_exec(16'hC005, 5'b00010);
        pin("model_beq_taken", int'(e.branch), 1);
        pin("model_beq_off", int'(e.b_offset), 5);
        e = model_exec(16'hC005, 5'b00000);
        pin("model_beq_not_taken", int'({e.branch, e.pc_en}), 1);
        e = model_exec(16'hCEFC, 5'b00000);
        pin("model_buc_off", int'(e.b_offset), 252);
        e = model_exec(16'h4583, 5'b00000);
        pin("model_jal", int'({e.jump, e.reg_we, e.wb_sel}), 14);
        e = model_exec(16'h02B1, 5'b00000);
        pin("model_cmp", int'({e.reg_we, e.flags_we}), 1);
        pin("model_len_load", model_len(16'h4103), 5);
        pin("model_len_stor", model_len(16'h4143), 4);
        pin("model_len_add", model_len(16'h0251), 3);
        pin("model_cond_lo", int'(cond_true(4'hA, 5'b00000)), 1);
        pin("model_cond_nv", int'(cond_true(4'hF, 5'b11111)), 0);

        // Reset for three cycles, then INIT for one cycle with all outputs low.
        @(posedge clk); #1; expect_cycle("reset_1", blank());
        @(posedge clk); #1; expect_cycle("reset_2", blank());
        @(posedge clk); #1; reset = 1'b0; expect_cycle("init", blank());
        @(posedge clk); #1;

        run("add",       16'h0251, 5'b00000);
        run("beq_z1",    16'hC005, 5'b00010);
        run("beq_z0",    16'hC005, 5'b00000);
        run("buc_m4",    16'hCEFC, 5'b00000);
        run("blo_taken", 16'hCA10, 5'b00000);
        run("bhs_not",   16'hCB10, 5'b00000);
        run("bcs_c1",    16'hC220, 5'b10000);
        run("blt_n1",    16'hCC30, 5'b00001);
        run("bnv",       16'hCF07, 5'b11111);
        run("cmp",       16'h02B1, 5'b00000);
        run("cmpi",      16'hB203, 5'b00000);
        run("addi",      16'h5203, 5'b00000);
        run("jeq_z1",    16'h40C3, 5'b00010);
        run("jeq_z0",    16'h40C3, 5'b00000);
        run("juc",       16'h4EC3, 5'b00000);
        run("jal",       16'h4583, 5'b00000);
        run("load",      16'h4103, 5'b00000);
        run("stor",      16'h4143, 5'b00000);
        run("nop_e",     16'hE000, 5'b00000);
        run("nop_ext",   16'h4123, 5'b00000);

        // Reset while in MEM_WR: the write strobe must not appear in the following cycle.
        push_instr("stor_rst", 16'h4143, 5'b00000);
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
        e = blank(); e.addr_sel = 1'b1; e.mem_we = 1'b1; e.pc_en = 1'b1;
        expect_cycle("stor_rst_memwr", e);
        sif.instr = 16'h4143;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        expect_cycle("stor_rst_init", blank());
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;
        run("add_after_rst", 16'h0251, 5'b00000);

`ifdef SEQ_MEM_WAIT_EN
        // Fetch stalled for three cycles: no ir_load until the ready cycle.
        sif.mem_rdy = 1'b0;
        sif.instr   = 16'h0251;
        for (int i = 0; i < 3; i++) expect_cycle("fetch_wait", blank());
        repeat (3) begin @(posedge clk); #1; end
        sif.mem_rdy = 1'b1;
        run("add_after_wait", 16'h0251, 5'b00000);

        // Sixteen stalled cycles time out: skip with pc_en, then mem_err sticks.
        sif.mem_rdy = 1'b0;
        for (int i = 0; i < 15; i++) expect_cycle("fetch_stall", blank());
        e = blank(); e.pc_en = 1'b1;
        expect_cycle("fetch_timeout", e);
        repeat (16) begin @(posedge clk); #1; end
        sif.mem_rdy = 1'b1;
        model_err   = 1'b1;
        run("add_after_tmo", 16'h0251, 5'b00000);
        run("load_after_tmo", 16'h4103, 5'b00000);
`endif

        pin("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
